tcp_rx_app_client: RTL and testbench
====================================

# tcp_rx_app_client

Application-tile client for the TCP RX pointer protocol. It issues single-flit RX pointer requests over the NoC to the TCP RX tile and receives the pointer response. It presents the granted buffer region to the application, then sends a head-adjust message when the application has consumed the data. It sits between an application engine and its NoC router port; exactly one request is outstanding at a time.

## Interface
Parameters:
- SRC_X, -1, this tile's X coordinate (source field of outgoing flits)
- SRC_Y, -1, this tile's Y coordinate
- DST_X, -1, TCP RX tile X coordinate
- DST_Y, -1, TCP RX tile Y coordinate
- RETRY_DELAY, 16, idle cycles before re-request (used only with retry compiled in)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- app_req_val / app_req_rdy  in/out  1  request handshake
- app_req_flowid  in  FLOWID_W  flow to read
- app_req_len  in  RX_PAYLOAD_PTR_W  max bytes wanted
- app_resp_val / app_resp_rdy  out/in  1  grant handshake
- app_resp_flowid  out  FLOWID_W  flow of grant
- app_resp_addr  out  RX_PAYLOAD_PTR_W  payload buffer base pointer
- app_resp_len  out  RX_PAYLOAD_PTR_W  bytes available (≤ app_req_len)
- app_done_val / app_done_rdy  in/out  1  consumption handshake
- app_done_flowid  in  FLOWID_W  flow consumed
- app_done_len  in  RX_PAYLOAD_PTR_W  bytes consumed
- client_noc_val / noc_client_rdy  out/in  1  outgoing flit handshake
- client_noc_data  out  NOC_DATA_WIDTH  outgoing flit
- noc_client_val / client_noc_rdy  in/out  1  incoming flit handshake
- noc_client_data  in  NOC_DATA_WIDTH  incoming flit
- client_err  out  1  sticky: response flowid mismatch seen

## Operation
- Flit format: tcp_rx_ptr_flit struct, with fields dst_x, dst_y, src_x, src_y, msg_type, flowid, addr, len. msg_type is one of RX_PTR_REQ, RX_PTR_RESP, RX_PTR_ADJ.
- FSM states: IDLE, SEND_REQ, WAIT_RESP, RESP_OUT, SEND_ADJ, BACKOFF (BACKOFF exists only with retry).
- IDLE: app_done_rdy=1 and app_req_rdy=!app_done_val, so done has priority. On done accept: latch flowid/len, go to SEND_ADJ. On req accept: latch flowid/len, go to SEND_REQ.
- SEND_REQ: client_noc_val=1 with an RX_PTR_REQ flit. On noc_client_rdy, go to WAIT_RESP.
- WAIT_RESP: client_noc_rdy=1.
  - RX_PTR_RESP flit with flowid equal to the latched flowid: latch addr, len=min(resp len, latched len), go to RESP_OUT.
  - Mismatched flowid or other msg_type: consume, drop, set client_err, stay.
- RESP_OUT: app_resp_val=1. On app_resp_rdy, go to IDLE.
- SEND_ADJ: client_noc_val=1 with an RX_PTR_ADJ flit (addr field 0). On noc_client_rdy, go to IDLE. No reply is expected.
- client_noc_rdy=1 in every state except RESP_OUT. Flits arriving outside WAIT_RESP are consumed and dropped with no error.
- Lengths are unsigned RX_PAYLOAD_PTR_W; min is an unsigned compare, with no wrap handling needed.

## Timing
- All outputs are registered or decoded from the state register. Reset value of every output is 0, except client_noc_rdy=1 and app_done_rdy=1 (IDLE decode). client_err resets to 0.
- Request accept to client_noc_val: 1 cycle.
- Response flit accept to app_resp_val: 1 cycle.
- Done accept to the adjust flit: 1 cycle.
- Val signals hold their data stable until the handshake completes.
- rst asserted mid-transaction: immediate return to IDLE. A response arriving afterward is dropped in IDLE.
- A response flit arriving in the same cycle the request flit is accepted is impossible: the state is still SEND_REQ, so the response is not yet expected. The response is handled on a later cycle in WAIT_RESP.

## Configuration
- TCP_RX_CLIENT_RETRY_EN defined: a matching response with len 0 moves the FSM to BACKOFF. BACKOFF counts RETRY_DELAY cycles, then goes to SEND_REQ with the same latched request. The app never sees a zero-length grant.
- Macro undefined: a zero-length grant is delivered through RESP_OUT like any other. No counter or BACKOFF state is built.

## Structure
- tcp_pkg holds: tcp_rx_ptr_flit struct, the msg_type enum values, FLOWID_W, RX_PAYLOAD_PTR_W.
- NOC_DATA_WIDTH and the XY width macros come from the existing NoC defines.
- One sub-module, tcp_rx_client_flit_fmt: combinational packing of request/adjust flits and unpacking of response flits. The FSM stays in the top.

## Test plan
- Request flowid 5, len 256; response flowid 5, addr 0x1000, len 100 → app_resp gives flowid 5, addr 0x1000, len 100. Request flit dst is (DST_X,DST_Y).
- Request len 64; response len 200 → app_resp_len=64.
- Response flowid 7 while waiting on 5, then the correct one → the first flit is dropped, client_err=1, the grant is delivered from the second.
- app_done_val and app_req_val asserted together in IDLE → the ADJ flit (flowid, len) is sent first, then the REQ flit.
- Response len 0 → with macro: a second REQ flit appears RETRY_DELAY+1 cycles later and no app_resp. Without macro: app_resp_len=0.
- rst pulsed during WAIT_RESP, then a stale response arrives → outputs return to reset values, the stale flit is consumed, no app_resp_val.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared types for the TCP RX pointer protocol: flit layout, message types and field widths.
// NoC widths mirror the platform NoC defines.
package tcp_pkg;

    localparam int unsigned NOC_DATA_WIDTH   = 128;
    localparam int unsigned XY_WIDTH         = 8;
    localparam int unsigned FLOWID_W         = 8;
    localparam int unsigned RX_PAYLOAD_PTR_W = 16;

    // Zero is left unused so an idle bus never decodes as a valid message.
    typedef enum logic [1:0] {
        RX_PTR_REQ  = 2'd1,
        RX_PTR_RESP = 2'd2,
        RX_PTR_ADJ  = 2'd3
    } tcp_rx_msg_e;

    typedef struct packed {
        logic [XY_WIDTH-1:0]         dst_x;
        logic [XY_WIDTH-1:0]         dst_y;
        logic [XY_WIDTH-1:0]         src_x;
        logic [XY_WIDTH-1:0]         src_y;
        tcp_rx_msg_e                 msg_type;
        logic [FLOWID_W-1:0]         flowid;
        logic [RX_PAYLOAD_PTR_W-1:0] addr;
        logic [RX_PAYLOAD_PTR_W-1:0] len;
    } tcp_rx_ptr_flit;

    localparam int unsigned FLIT_W     = $bits(tcp_rx_ptr_flit);
    localparam int unsigned FLIT_PAD_W = NOC_DATA_WIDTH - FLIT_W;

endpackage

// File: rtl/tcp_rx_client_flit_fmt.sv
// Combinational packing of outgoing REQ/ADJ flits and unpacking of incoming response flits.
module tcp_rx_client_flit_fmt import tcp_pkg::*; #(
    parameter int SRC_X = -1,
    parameter int SRC_Y = -1,
    parameter int DST_X = -1,
    parameter int DST_Y = -1
) (
    input  logic                        tx_en_i,
    input  logic [1:0]                  tx_type_i,
    input  logic [FLOWID_W-1:0]         tx_flowid_i,
    input  logic [RX_PAYLOAD_PTR_W-1:0] tx_len_i,
    output logic [NOC_DATA_WIDTH-1:0]   tx_data_o,
    input  logic [NOC_DATA_WIDTH-1:0]   rx_data_i,
    output logic                        rx_is_resp_o,
    output logic [FLOWID_W-1:0]         rx_flowid_o,
    output logic [RX_PAYLOAD_PTR_W-1:0] rx_addr_o,
    output logic [RX_PAYLOAD_PTR_W-1:0] rx_len_o
);

    tcp_rx_ptr_flit tx_flit;
    tcp_rx_ptr_flit rx_flit;
    logic           unused_rx;

    always_comb begin
        tx_flit          = '0;
        tx_flit.dst_x    = XY_WIDTH'(DST_X);
        tx_flit.dst_y    = XY_WIDTH'(DST_Y);
        tx_flit.src_x    = XY_WIDTH'(SRC_X);
        tx_flit.src_y    = XY_WIDTH'(SRC_Y);
        tx_flit.msg_type = tcp_rx_msg_e'(tx_type_i);
        tx_flit.flowid   = tx_flowid_i;
        tx_flit.addr     = '0;
        tx_flit.len      = tx_len_i;
    end

    // Bus reads as zero whenever no flit is being offered.
    assign tx_data_o = tx_en_i ? {{FLIT_PAD_W{1'b0}}, tx_flit} : '0;

    assign rx_flit      = tcp_rx_ptr_flit'(rx_data_i[FLIT_W-1:0]);
    assign rx_is_resp_o = (rx_flit.msg_type == RX_PTR_RESP);
    assign rx_flowid_o  = rx_flit.flowid;
    assign rx_addr_o    = rx_flit.addr;
    assign rx_len_o     = rx_flit.len;

    assign unused_rx = ^{rx_data_i[NOC_DATA_WIDTH-1:FLIT_W], rx_flit.dst_x, rx_flit.dst_y,
                         rx_flit.src_x, rx_flit.src_y};

endmodule

// File: rtl/tcp_rx_app_client.sv
// Application-side client for the TCP RX pointer protocol; one request outstanding at a time.
// Optional zero-length-grant retry with backoff is enabled by defining TCP_RX_CLIENT_RETRY_EN.
module tcp_rx_app_client import tcp_pkg::*; #(
    parameter int          SRC_X       = -1,
    parameter int          SRC_Y       = -1,
    parameter int          DST_X       = -1,
    parameter int          DST_Y       = -1,
    parameter int unsigned RETRY_DELAY = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        app_req_val,
    output logic                        app_req_rdy,
    input  logic [FLOWID_W-1:0]         app_req_flowid,
    input  logic [RX_PAYLOAD_PTR_W-1:0] app_req_len,
    output logic                        app_resp_val,
    input  logic                        app_resp_rdy,
    output logic [FLOWID_W-1:0]         app_resp_flowid,
    output logic [RX_PAYLOAD_PTR_W-1:0] app_resp_addr,
    output logic [RX_PAYLOAD_PTR_W-1:0] app_resp_len,
    input  logic                        app_done_val,
    output logic                        app_done_rdy,
    input  logic [FLOWID_W-1:0]         app_done_flowid,
    input  logic [RX_PAYLOAD_PTR_W-1:0] app_done_len,
    output logic                        client_noc_val,
    input  logic                        noc_client_rdy,
    output logic [NOC_DATA_WIDTH-1:0]   client_noc_data,
    input  logic                        noc_client_val,
    output logic                        client_noc_rdy,
    input  logic [NOC_DATA_WIDTH-1:0]   noc_client_data,
    output logic                        client_err
);

`ifdef TCP_RX_CLIENT_RETRY_EN
    typedef enum logic [2:0] {
        StIdle = 3'd0, StSendReq = 3'd1, StWaitResp = 3'd2, StRespOut = 3'd3, StSendAdj = 3'd4,
        StBackoff = 3'd5
    } state_e;
    localparam int unsigned CntW = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(RETRY_DELAY - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [2:0] {
        StIdle = 3'd0, StSendReq = 3'd1, StWaitResp = 3'd2, StRespOut = 3'd3, StSendAdj = 3'd4
    } state_e;
    localparam int unsigned unused_retry_delay = RETRY_DELAY;
`endif

    state_e                      state_q, state_d;
    logic [FLOWID_W-1:0]         flowid_q, flowid_d;
    logic [RX_PAYLOAD_PTR_W-1:0] len_q, len_d;
    logic [RX_PAYLOAD_PTR_W-1:0] addr_q, addr_d;
    logic [RX_PAYLOAD_PTR_W-1:0] grant_len_q, grant_len_d;
    logic                        err_q, err_d;

    logic                        tx_en;
    logic [1:0]                  tx_type;
    logic                        rx_is_resp;
    logic [FLOWID_W-1:0]         rx_flowid;
    logic [RX_PAYLOAD_PTR_W-1:0] rx_addr;
    logic [RX_PAYLOAD_PTR_W-1:0] rx_len;
    logic                        resp_match;

    tcp_rx_client_flit_fmt #(
        .SRC_X(SRC_X),
        .SRC_Y(SRC_Y),
        .DST_X(DST_X),
        .DST_Y(DST_Y)
    ) u_flit_fmt (
        .tx_en_i     (tx_en),
        .tx_type_i   (tx_type),
        .tx_flowid_i (flowid_q),
        .tx_len_i    (len_q),
        .tx_data_o   (client_noc_data),
        .rx_data_i   (noc_client_data),
        .rx_is_resp_o(rx_is_resp),
        .rx_flowid_o (rx_flowid),
        .rx_addr_o   (rx_addr),
        .rx_len_o    (rx_len)
    );

    assign resp_match = noc_client_val && rx_is_resp && (rx_flowid == flowid_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (app_done_val) begin
                    state_d = StSendAdj;
                end else if (app_req_val) begin
                    state_d = StSendReq;
                end
            end
            StSendReq:  if (noc_client_rdy) state_d = StWaitResp;
            StWaitResp: begin
                if (resp_match) begin
`ifdef TCP_RX_CLIENT_RETRY_EN
                    state_d = (rx_len == '0) ? StBackoff : StRespOut;
`else
                    state_d = StRespOut;
`endif
                end
            end
            StRespOut:  if (app_resp_rdy) state_d = StIdle;
            StSendAdj:  if (noc_client_rdy) state_d = StIdle;
`ifdef TCP_RX_CLIENT_RETRY_EN
            StBackoff:  if (cnt_q == CntLast) state_d = StSendReq;
`endif
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        app_req_rdy    = 1'b0;
        app_done_rdy   = 1'b0;
        app_resp_val   = 1'b0;
        client_noc_val = 1'b0;
        client_noc_rdy = 1'b1;
        tx_type        = RX_PTR_REQ;
        case (state_q)
            StIdle: begin
                app_done_rdy = 1'b1;
                app_req_rdy  = !app_done_val;
            end
            StSendReq:  client_noc_val = 1'b1;
            StRespOut: begin
                app_resp_val   = 1'b1;
                client_noc_rdy = 1'b0;
            end
            StSendAdj: begin
                client_noc_val = 1'b1;
                tx_type        = RX_PTR_ADJ;
            end
            default: ;
        endcase
    end

    assign tx_en = client_noc_val;

    // Datapath: latch request/done fields in IDLE, grant fields on a matching response.
    always_comb begin
        flowid_d    = flowid_q;
        len_d       = len_q;
        addr_d      = addr_q;
        grant_len_d = grant_len_q;
        err_d       = err_q;
        if (state_q == StIdle && app_done_val) begin
            flowid_d = app_done_flowid;
            len_d    = app_done_len;
        end else if (state_q == StIdle && app_req_val) begin
            flowid_d = app_req_flowid;
            len_d    = app_req_len;
        end
        if (state_q == StWaitResp && resp_match) begin
            addr_d      = rx_addr;
            grant_len_d = (rx_len < len_q) ? rx_len : len_q;
        end
        if (state_q == StWaitResp && noc_client_val && !resp_match) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flowid_q    <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            grant_len_q <= '0;
            err_q       <= 1'b0;
        end else begin
            flowid_q    <= flowid_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            grant_len_q <= grant_len_d;
            err_q       <= err_d;
        end
    end

`ifdef TCP_RX_CLIENT_RETRY_EN
    assign cnt_d = (state_q == StBackoff) ? CntW'(cnt_q + 1'b1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign app_resp_flowid = flowid_q;
    assign app_resp_addr   = addr_q;
    assign app_resp_len    = grant_len_q;
    assign client_err      = err_q;

endmodule

// File: tb/tb_tcp_rx_app_client.sv
// Self-checking bench for tcp_rx_app_client: directed protocol scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_tcp_rx_app_client;
    import tcp_pkg::*;

    localparam int          SRC_X       = 1;
    localparam int          SRC_Y       = 2;
    localparam int          DST_X       = 3;
    localparam int          DST_Y       = 4;
    localparam int unsigned RETRY_DELAY = 5;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        app_req_val = 1'b0, app_req_rdy;
    logic [FLOWID_W-1:0]         app_req_flowid = '0;
    logic [RX_PAYLOAD_PTR_W-1:0] app_req_len = '0;
    logic                        app_resp_val, app_resp_rdy = 1'b0;
    logic [FLOWID_W-1:0]         app_resp_flowid;
    logic [RX_PAYLOAD_PTR_W-1:0] app_resp_addr, app_resp_len;
    logic                        app_done_val = 1'b0, app_done_rdy;
    logic [FLOWID_W-1:0]         app_done_flowid = '0;
    logic [RX_PAYLOAD_PTR_W-1:0] app_done_len = '0;
    logic                        client_noc_val, noc_client_rdy = 1'b0;
    logic [NOC_DATA_WIDTH-1:0]   client_noc_data;
    logic                        noc_client_val = 1'b0, client_noc_rdy;
    logic [NOC_DATA_WIDTH-1:0]   noc_client_data = '0;
    logic                        client_err;

    int checks   = 0;
    int failures = 0;
    bit err_model = 1'b0;

    tcp_rx_app_client #(
        .SRC_X(SRC_X), .SRC_Y(SRC_Y), .DST_X(DST_X), .DST_Y(DST_Y), .RETRY_DELAY(RETRY_DELAY)
    ) dut (
        .clk(clk), .rst(rst),
        .app_req_val(app_req_val), .app_req_rdy(app_req_rdy),
        .app_req_flowid(app_req_flowid), .app_req_len(app_req_len),
        .app_resp_val(app_resp_val), .app_resp_rdy(app_resp_rdy),
        .app_resp_flowid(app_resp_flowid), .app_resp_addr(app_resp_addr),
        .app_resp_len(app_resp_len),
        .app_done_val(app_done_val), .app_done_rdy(app_done_rdy),
        .app_done_flowid(app_done_flowid), .app_done_len(app_done_len),
        .client_noc_val(client_noc_val), .noc_client_rdy(noc_client_rdy),
        .client_noc_data(client_noc_data),
        .noc_client_val(noc_client_val), .client_noc_rdy(client_noc_rdy),
        .noc_client_data(noc_client_data),
        .client_err(client_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the grant is the smaller of asked and offered byte counts.
    function automatic int exp_grant_len(input int asked, input int offered);
        return (offered < asked) ? offered : asked;
    endfunction

    function automatic logic [NOC_DATA_WIDTH-1:0] mk_flit(input tcp_rx_msg_e t,
            input logic [FLOWID_W-1:0] fid, input logic [RX_PAYLOAD_PTR_W-1:0] addr,
            input logic [RX_PAYLOAD_PTR_W-1:0] len);
        tcp_rx_ptr_flit f;
        f.dst_x = XY_WIDTH'(SRC_X);
        f.dst_y = XY_WIDTH'(SRC_Y);
        f.src_x = XY_WIDTH'(DST_X);
        f.src_y = XY_WIDTH'(DST_Y);
        f.msg_type = t;
        f.flowid = fid;
        f.addr = addr;
        f.len = len;
        return {{FLIT_PAD_W{1'b0}}, f};
    endfunction

    task automatic do_req(input logic [FLOWID_W-1:0] fid,
                          input logic [RX_PAYLOAD_PTR_W-1:0] len, output bit ok);
        ok = 1'b0;
        app_req_val = 1'b1; app_req_flowid = fid; app_req_len = len;
        #1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (app_req_rdy) ok = 1'b1;
            tick();
        end
        app_req_val = 1'b0;
    endtask

    task automatic do_done(input logic [FLOWID_W-1:0] fid,
                           input logic [RX_PAYLOAD_PTR_W-1:0] len, output bit ok);
        ok = 1'b0;
        app_done_val = 1'b1; app_done_flowid = fid; app_done_len = len;
        #1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (app_done_rdy) ok = 1'b1;
            tick();
        end
        app_done_val = 1'b0;
    endtask

    task automatic get_flit(input int stall, output tcp_rx_ptr_flit f, output bit ok,
                            output bit stable, output int waited);
        logic [NOC_DATA_WIDTH-1:0] d;
        ok = 1'b0; stable = 1'b1; waited = 0; f = '0;
        noc_client_rdy = 1'b0;
        while (!client_noc_val && waited < 60) begin
            tick();
            waited++;
        end
        if (!client_noc_val) return;
        d = client_noc_data;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!client_noc_val || client_noc_data !== d) stable = 1'b0;
        end
        noc_client_rdy = 1'b1;
        #1;
        tick();
        noc_client_rdy = 1'b0;
        f = tcp_rx_ptr_flit'(d[FLIT_W-1:0]);
        ok = 1'b1;
    endtask

    task automatic put_flit(input logic [NOC_DATA_WIDTH-1:0] d, output bit ok);
        ok = 1'b0;
        noc_client_val = 1'b1; noc_client_data = d;
        #1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (client_noc_rdy) ok = 1'b1;
            tick();
        end
        noc_client_val = 1'b0; noc_client_data = '0;
    endtask

    task automatic get_grant(output logic [FLOWID_W-1:0] fid,
                             output logic [RX_PAYLOAD_PTR_W-1:0] addr,
                             output logic [RX_PAYLOAD_PTR_W-1:0] len, output bit ok,
                             output int waited);
        ok = 1'b0; waited = 0; fid = '0; addr = '0; len = '0;
        while (!app_resp_val && waited < 60) begin
            tick();
            waited++;
        end
        if (!app_resp_val) return;
        fid = app_resp_flowid; addr = app_resp_addr; len = app_resp_len;
        app_resp_rdy = 1'b1;
        #1;
        tick();
        app_resp_rdy = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        app_done_val = 1'b1;
        tick(); tick();
        checks++;
        if ({client_noc_val, app_resp_val, client_err, app_req_rdy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_zero_ctrl: got %b required 0000",
                     {client_noc_val, app_resp_val, client_err, app_req_rdy});
        end
        checks++;
        if ({client_noc_rdy, app_done_rdy} !== 2'b11) begin
            failures++;
            $display("FAIL reset_rdy: got %b required 11", {client_noc_rdy, app_done_rdy});
        end
        checks++;
        if (client_noc_data !== '0 || app_resp_addr !== '0 || app_resp_len !== '0 ||
            app_resp_flowid !== '0) begin
            failures++;
            $display("FAIL reset_data: noc=%0h addr=%0h len=%0h fid=%0h required 0",
                     client_noc_data, app_resp_addr, app_resp_len, app_resp_flowid);
        end
        app_done_val = 1'b0;
        #1 rst = 1'b0;
        err_model = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok, stable; int w; tcp_rx_ptr_flit f;
        logic [FLOWID_W-1:0] gf; logic [RX_PAYLOAD_PTR_W-1:0] ga, gl;
        do_req(8'd5, 16'd256, ok);
        get_flit(2, f, ok, stable, w);
        checks++;
        if (!ok || w != 0 || !stable) begin
            failures++;
            $display("FAIL basic_req_flit: ok=%0d wait=%0d stable=%0d required 1/0/1", ok, w,
                     stable);
        end
        checks++;
        if (f.msg_type !== RX_PTR_REQ || f.flowid !== 8'd5 || f.len !== 16'd256 ||
            f.addr !== '0) begin
            failures++;
            $display("FAIL basic_req_fields: type=%0d fid=%0d len=%0d addr=%0h required 1/5/256/0",
                     f.msg_type, f.flowid, f.len, f.addr);
        end
        checks++;
        if (f.dst_x !== XY_WIDTH'(DST_X) || f.dst_y !== XY_WIDTH'(DST_Y) ||
            f.src_x !== XY_WIDTH'(SRC_X) || f.src_y !== XY_WIDTH'(SRC_Y)) begin
            failures++;
            $display("FAIL basic_req_xy: dst=(%0d,%0d) src=(%0d,%0d) required (%0d,%0d) (%0d,%0d)",
                     f.dst_x, f.dst_y, f.src_x, f.src_y, DST_X, DST_Y, SRC_X, SRC_Y);
        end
        put_flit(mk_flit(RX_PTR_RESP, 8'd5, 16'h1000, 16'd100), ok);
        get_grant(gf, ga, gl, ok, w);
        checks++;
        if (!ok || w != 0 || gf !== 8'd5 || ga !== 16'h1000 || gl !== 16'd100) begin
            failures++;
            $display("FAIL basic_grant: ok=%0d wait=%0d fid=%0d addr=%0h len=%0d required 1/0/5/1000/100",
                     ok, w, gf, ga, gl);
        end
        checks++;
        if (client_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_err: got %b required 0", client_err);
        end
    endtask

    task automatic test_clamp();
        bit ok, stable; int w; tcp_rx_ptr_flit f;
        logic [FLOWID_W-1:0] gf; logic [RX_PAYLOAD_PTR_W-1:0] ga, gl;
        do_req(8'd9, 16'd64, ok);
        get_flit(0, f, ok, stable, w);
        put_flit(mk_flit(RX_PTR_RESP, 8'd9, 16'h2000, 16'd200), ok);
        get_grant(gf, ga, gl, ok, w);
        checks++;
        if (!ok || gf !== 8'd9 || ga !== 16'h2000 || gl !== 16'(exp_grant_len(64, 200))) begin
            failures++;
            $display("FAIL clamp_grant: ok=%0d fid=%0d addr=%0h len=%0d required 1/9/2000/64",
                     ok, gf, ga, gl);
        end
    endtask

    task automatic test_mismatch();
        bit ok, stable; int w; tcp_rx_ptr_flit f;
        logic [FLOWID_W-1:0] gf; logic [RX_PAYLOAD_PTR_W-1:0] ga, gl;
        do_req(8'd5, 16'd128, ok);
        get_flit(0, f, ok, stable, w);
        put_flit(mk_flit(RX_PTR_RESP, 8'd7, 16'h0bad, 16'd10), ok);
        err_model = 1'b1;
        checks++;
        if (!ok || client_err !== 1'b1 || app_resp_val !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_drop: ok=%0d err=%b resp_val=%b required 1/1/0", ok,
                     client_err, app_resp_val);
        end
        put_flit(mk_flit(RX_PTR_ADJ, 8'd5, 16'h0bad, 16'd11), ok);
        checks++;
        if (!ok || app_resp_val !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_type_drop: ok=%0d resp_val=%b required 1/0", ok, app_resp_val);
        end
        put_flit(mk_flit(RX_PTR_RESP, 8'd5, 16'h3000, 16'd50), ok);
        get_grant(gf, ga, gl, ok, w);
        checks++;
        if (!ok || gf !== 8'd5 || ga !== 16'h3000 || gl !== 16'd50 || client_err !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_grant: ok=%0d fid=%0d addr=%0h len=%0d err=%b required 1/5/3000/50/1",
                     ok, gf, ga, gl, client_err);
        end
    endtask

    task automatic test_done_priority();
        bit ok, stable; int w; tcp_rx_ptr_flit f;
        logic [FLOWID_W-1:0] gf; logic [RX_PAYLOAD_PTR_W-1:0] ga, gl;
        app_done_val = 1'b1; app_done_flowid = 8'd3; app_done_len = 16'd77;
        app_req_val = 1'b1; app_req_flowid = 8'd4; app_req_len = 16'd300;
        #1;
        checks++;
        if (app_done_rdy !== 1'b1 || app_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL prio_rdy: done_rdy=%b req_rdy=%b required 1/0", app_done_rdy,
                     app_req_rdy);
        end
        tick();
        app_done_val = 1'b0;
        get_flit(1, f, ok, stable, w);
        checks++;
        if (!ok || w != 0 || f.msg_type !== RX_PTR_ADJ || f.flowid !== 8'd3 ||
            f.len !== 16'd77 || f.addr !== '0) begin
            failures++;
            $display("FAIL prio_adj: ok=%0d wait=%0d type=%0d fid=%0d len=%0d addr=%0h required 1/0/3/3/77/0",
                     ok, w, f.msg_type, f.flowid, f.len, f.addr);
        end
        do_req(8'd4, 16'd300, ok);
        get_flit(0, f, ok, stable, w);
        checks++;
        if (!ok || f.msg_type !== RX_PTR_REQ || f.flowid !== 8'd4 || f.len !== 16'd300) begin
            failures++;
            $display("FAIL prio_req: ok=%0d type=%0d fid=%0d len=%0d required 1/1/4/300", ok,
                     f.msg_type, f.flowid, f.len);
        end
        put_flit(mk_flit(RX_PTR_RESP, 8'd4, 16'h0044, 16'd10), ok);
        get_grant(gf, ga, gl, ok, w);
        checks++;
        if (!ok || gf !== 8'd4 || gl !== 16'd10) begin
            failures++;
            $display("FAIL prio_grant: ok=%0d fid=%0d len=%0d required 1/4/10", ok, gf, gl);
        end
    endtask

    task automatic test_zero_len();
        bit ok, stable; int w; tcp_rx_ptr_flit f;
        logic [FLOWID_W-1:0] gf; logic [RX_PAYLOAD_PTR_W-1:0] ga, gl;
        do_req(8'd6, 16'd100, ok);
        get_flit(0, f, ok, stable, w);
        put_flit(mk_flit(RX_PTR_RESP, 8'd6, 16'h0500, 16'd0), ok);
`ifdef TCP_RX_CLIENT_RETRY_EN
        begin
            int n; bit seen;
            n = 1; seen = 1'b0;
            while (!client_noc_val && n < 200) begin
                if (app_resp_val) seen = 1'b1;
                tick();
                n++;
            end
            checks++;
            if (n != int'(RETRY_DELAY) + 1 || seen) begin
                failures++;
                $display("FAIL zero_retry: cycles=%0d grant_seen=%0d required %0d/0", n, seen,
                         RETRY_DELAY + 1);
            end
        end
        get_flit(0, f, ok, stable, w);
        checks++;
        if (!ok || f.msg_type !== RX_PTR_REQ || f.flowid !== 8'd6 || f.len !== 16'd100) begin
            failures++;
            $display("FAIL zero_rereq: ok=%0d type=%0d fid=%0d len=%0d required 1/1/6/100", ok,
                     f.msg_type, f.flowid, f.len);
        end
        put_flit(mk_flit(RX_PTR_RESP, 8'd6, 16'h0600, 16'd40), ok);
        get_grant(gf, ga, gl, ok, w);
        checks++;
        if (!ok || gf !== 8'd6 || ga !== 16'h0600 || gl !== 16'd40) begin
            failures++;
            $display("FAIL zero_final_grant: ok=%0d fid=%0d addr=%0h len=%0d required 1/6/600/40",
                     ok, gf, ga, gl);
        end
`else
        get_grant(gf, ga, gl, ok, w);
        checks++;
        if (!ok || gf !== 8'd6 || ga !== 16'h0500 || gl !== 16'd0) begin
            failures++;
            $display("FAIL zero_grant: ok=%0d fid=%0d addr=%0h len=%0d required 1/6/500/0", ok,
                     gf, ga, gl);
        end
`endif
    endtask

    task automatic test_random();
        bit ok, stable; int w; tcp_rx_ptr_flit f;
        logic [FLOWID_W-1:0] gf, fid, bad; logic [RX_PAYLOAD_PTR_W-1:0] ga, gl, addr;
        int qlen, rlen, stall;
        for (int it = 0; it < 24; it++) begin
            fid = FLOWID_W'($urandom_range(0, 255));
            qlen = $urandom_range(1, 1000);
            rlen = $urandom_range(1, 1000);
            addr = RX_PAYLOAD_PTR_W'($urandom);
            stall = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                do_done(fid, 16'(rlen), ok);
                get_flit(stall, f, ok, stable, w);
                checks++;
                if (!ok || !stable || f.msg_type !== RX_PTR_ADJ || f.flowid !== fid ||
                    f.len !== 16'(rlen)) begin
                    failures++;
                    $display("FAIL rand_adj[%0d]: ok=%0d stable=%0d type=%0d fid=%0d len=%0d required 1/1/3/%0d/%0d",
                             it, ok, stable, f.msg_type, f.flowid, f.len, fid, rlen);
                end
            end
            do_req(fid, 16'(qlen), ok);
            get_flit(stall, f, ok, stable, w);
            checks++;
            if (!ok || !stable || f.msg_type !== RX_PTR_REQ || f.flowid !== fid ||
                f.len !== 16'(qlen)) begin
                failures++;
                $display("FAIL rand_req[%0d]: ok=%0d stable=%0d type=%0d fid=%0d len=%0d required 1/1/1/%0d/%0d",
                         it, ok, stable, f.msg_type, f.flowid, f.len, fid, qlen);
            end
            if ($urandom_range(0, 2) == 0) begin
                bad = fid ^ FLOWID_W'($urandom_range(1, 255));
                put_flit(mk_flit(RX_PTR_RESP, bad, addr, 16'(rlen)), ok);
                err_model = 1'b1;
            end
            put_flit(mk_flit(RX_PTR_RESP, fid, addr, 16'(rlen)), ok);
            get_grant(gf, ga, gl, ok, w);
            checks++;
            if (!ok || gf !== fid || ga !== addr || gl !== 16'(exp_grant_len(qlen, rlen)) ||
                client_err !== err_model) begin
                failures++;
                $display("FAIL rand_grant[%0d]: ok=%0d fid=%0d addr=%0h len=%0d err=%b required 1/%0d/%0h/%0d/%b",
                         it, ok, gf, ga, gl, client_err, fid, addr, exp_grant_len(qlen, rlen),
                         err_model);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, stable, seen; int w; tcp_rx_ptr_flit f;
        do_req(8'd2, 16'd50, ok);
        get_flit(0, f, ok, stable, w);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({client_noc_val, app_resp_val, client_err} !== 3'b000 ||
            {client_noc_rdy, app_done_rdy, app_req_rdy} !== 3'b111 || client_noc_data !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: val/resp/err=%b rdys=%b required 000/111",
                     {client_noc_val, app_resp_val, client_err},
                     {client_noc_rdy, app_done_rdy, app_req_rdy});
        end
        rst = 1'b0;
        err_model = 1'b0;
        put_flit(mk_flit(RX_PTR_RESP, 8'd2, 16'h0077, 16'd30), ok);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (app_resp_val) seen = 1'b1;
            tick();
        end
        checks++;
        if (!ok || seen || client_err !== 1'b0 || app_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_stale: consumed=%0d grant_seen=%0d err=%b req_rdy=%b required 1/0/0/1",
                     ok, seen, client_err, app_req_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_mismatch();
        test_done_priority();
        test_zero_len();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
